sincos_dds: RTL and testbench
=============================

# sincos_dds

Parametrised quadrature tone generator: successor to the half-wave `sincos_mem` table reader. Holds a host-loaded quarter-wave {cos,sin} table and steps through it with a phase accumulator (programmable step and offset), so tone frequency is set without reloading the table. Quadrant folding, gain scaling and OFF/DC/TONE modes are included. Sits between the register bus and the DAC/modulator PCM path, feeding I/Q samples over a valid/ready stream.

## Interface
- `DW`, 16: sample width; table entry is 2·DW bits, {cos,sin}.
- `TAW`, 10: table address width; 2^TAW entries cover one quadrant [0, π/2).
- `PW`, 32: phase accumulator width; must satisfy PW ≥ TAW+2.
- `UNIT1`, 2^(DW-2): DC-mode I level.

Ports:
- `da_clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `pcm_out_valid`  out  1  sample valid.
- `pcm_out_ready`  in  1  sink ready.
- `ipcm_out`  out  DW  I sample, signed.
- `qpcm_out`  out  DW  Q sample, signed.
- `reg_addr`  in  TAW  table index.
- `reg_rd`  in  1  table read request; held until `reg_ready`.
- `reg_wr`  in  1  table write request; held until `reg_ready`.
- `reg_ready`  out  1  request completion strobe.
- `reg_writedata`  in  2·DW  {cos,sin}.
- `reg_readdata`  out  2·DW  table read data.
- `mode`  in  2  0=OFF, 1=DC, 2=TONE, 3=OFF.
- `phase_step`  in  PW  accumulator increment per sample.
- `phase_offset`  in  PW  added to the accumulator before lookup.
- `gain`  in  DW  unsigned; 2^(DW-1) = 1.0.
- `resync`  in  1  restart from phase 0 and flush the pipeline.
- `status`  out  TAW+2  `acc[PW-1:PW-TAW-2]`, i.e. {quadrant, index}.

## Operation
- Advance: `adv = pcm_out_ready | !pcm_out_valid`. All pipeline stages, including the RAM read enable, move only on `adv`.
- Accumulator:
  - On `adv` in TONE: `acc <= acc + phase_step`, mod 2^PW.
  - In OFF/DC: `acc` is held at 0, so entering TONE always starts at phase 0.
- Sample n has phase `phase_offset + n·phase_step`.
- Lookup: `p = acc + phase_offset`. Quadrant `qd = p[PW-1:PW-2]`. Index `k = p[PW-3:PW-2-TAW]`. Lower bits are truncated.
- Quadrant map, with (c,s) = table[k]:
  - qd 0 → (c, s)
  - qd 1 → (−s, c)
  - qd 2 → (−c, −s)
  - qd 3 → (s, −c)
- Table values are confined to ±(2^(DW-1)−1), so negation never overflows.
- Gain:
  - `g = min(gain, 2^(DW-1))`.
  - `out = (v·g) >>> (DW-1)`: signed, arithmetic shift, truncation toward −∞.
  - g = 2^(DW-1) passes v unchanged.
- Mode is applied at the output stage:
  - OFF: I=Q=0.
  - DC: I=UNIT1, Q=0, gain not applied.
  - TONE: scaled quadrant-mapped sample.
- Table port:
  - Shares `da_clk`.
  - `reg_ready` toggles each cycle while `reg_rd|reg_wr` is held and is 0 otherwise.
  - A write commits on every cycle `reg_wr` is high; repeated writes of the same data are harmless.
  - `reg_readdata` is valid when `reg_ready`=1.
- Simultaneous host write and tone read of the same address: the tone read returns either the old or the new entry. The table is not required to be coherent while TONE is running.

## Timing
- Pipeline: P0 phase/address register → P1 RAM read (1-cycle latency) → P2 quadrant map → P3 gain/mode output register. Total latency is 4 advances. A per-stage valid bit accompanies the quadrant bits.
- `rst` or `resync` (rst dominant):
  - Next edge: `acc`=0, all stage valids 0, `pcm_out_valid`=0, `ipcm_out`=`qpcm_out`=0.
  - `rst` also clears `reg_ready` to 0.
  - First `pcm_out_valid`=1 occurs on the 4th edge after release, carrying phase `phase_offset`.
- Backpressure: while `pcm_out_valid & !pcm_out_ready`, all outputs, `acc`, `status` and the stage registers hold. No sample is dropped or duplicated.
- `mode`, `gain`, `phase_step`, `phase_offset` are sampled on `adv`. A change reaches the output within 4 advances; no glitch recovery is required.

## Structure
- Shared package: mode encodings (`MODE_OFF`, `MODE_DC`, `MODE_TONE`), quadrant encodings, and the pipeline depth constant `SDDS_LAT=4`.
- Sub-module: `generic_dpram` (adw=bdw=2·DW, aaw=TAW, both clocks `da_clk`). Port A is the tone read with `rden_a=adv`; port B is the register access.
- Quadrant map and gain stage stay inline.

## Test plan
All scenarios use DW=16, TAW=10, PW=32.
1. Reset/DC:
   - `rst` high → all outputs 0, `reg_ready`=0.
   - Release with mode=1 → `pcm_out_valid` on the 4th edge, I=0x4000, Q=0.
2. Quadrant walk:
   - Load entry 0 = 0x7FFF_0000; set step=0x4000_0000, offset=0, gain=0x8000, mode=2, ready=1.
   - Required repeating I/Q: (7FFF,0000), (0000,7FFF), (8001,0000), (0000,8001).
3. Backpressure:
   - Drop ready for 5 cycles during scenario 2 → outputs and `status` frozen.
   - On release the sequence resumes with no skipped or repeated sample.
4. Offset/gain:
   - Entry 512 = 0x5A82_5A82; offset=0x2000_0000, step=0, gain=0x4000 → I=Q=0x2D41.
   - gain=0xFFFF → saturates to unity, I=Q=0x5A82.
5. Resync mid-stream:
   - `pcm_out_valid` falls on the next edge.
   - 4 edges later the first sample equals the phase-`offset` entry, mapped per its quadrant.
6. Register path:
   - Write entry 3 = 0x1234_5678 (hold `reg_wr` until `reg_ready`).
   - Read entry 3 back → `reg_readdata`=0x1234_5678 with `reg_ready`=1.
   - `reg_ready` returns to 0 once `reg_rd` drops.

Source files
------------

// File: rtl/sincos_dds_pkg.sv
// Shared encodings for the quarter-wave quadrature tone generator.
package sincos_dds_pkg;

  localparam int SDDS_LAT = 4;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_DC      = 2'd1,
    MODE_TONE    = 2'd2,
    MODE_OFF_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    QD_0   = 2'd0,
    QD_90  = 2'd1,
    QD_180 = 2'd2,
    QD_270 = 2'd3
  } quad_e;

endpackage

// File: rtl/generic_dpram.sv
// Dual-port RAM: registered read on both ports, port B also writes.
module generic_dpram #(
  parameter int adw = 32,
  parameter int bdw = 32,
  parameter int aaw = 10
) (
  input  logic           clk_a,
  input  logic [aaw-1:0] addr_a,
  input  logic           rden_a,
  output logic [adw-1:0] q_a,
  input  logic           clk_b,
  input  logic [aaw-1:0] addr_b,
  input  logic           rden_b,
  input  logic           wren_b,
  input  logic [bdw-1:0] data_b,
  output logic [bdw-1:0] q_b
);

  // NOTE: the storage array has no reset; clearing it would force it out of block RAM into flops.
  logic [adw-1:0] mem [2**aaw];

  always_ff @(posedge clk_a) begin
    if (rden_a) q_a <= mem[addr_a];
  end

  always_ff @(posedge clk_b) begin
    if (wren_b) mem[addr_b] <= data_b;
    if (rden_b) q_b <= mem[addr_b];
  end

endmodule

// File: rtl/sincos_dds.sv
// Quadrature DDS: phase accumulator, quarter-wave table, quadrant fold, gain and mode.
module sincos_dds
  import sincos_dds_pkg::*;
#(
  parameter int DW    = 16,
  parameter int TAW   = 10,
  parameter int PW    = 32,
  parameter int UNIT1 = 2**(DW-2)
) (
  input  logic            da_clk,
  input  logic            rst,
  output logic            pcm_out_valid,
  input  logic            pcm_out_ready,
  output logic [DW-1:0]   ipcm_out,
  output logic [DW-1:0]   qpcm_out,
  input  logic [TAW-1:0]  reg_addr,
  input  logic            reg_rd,
  input  logic            reg_wr,
  output logic            reg_ready,
  input  logic [2*DW-1:0] reg_writedata,
  output logic [2*DW-1:0] reg_readdata,
  input  logic [1:0]      mode,
  input  logic [PW-1:0]   phase_step,
  input  logic [PW-1:0]   phase_offset,
  input  logic [DW-1:0]   gain,
  input  logic            resync,
  output logic [TAW+1:0]  status
);

  localparam logic [DW-1:0] GAIN_ONE = {1'b1, {(DW-1){1'b0}}};

  logic            adv, flush;
  logic [PW-1:0]   acc;
  logic [TAW+1:0]  phase_top;
  logic [1:0]      p0_qd, p1_qd;
  logic [TAW-1:0]  p0_idx;
  logic            p0_vld, p1_vld, p2_vld;
  logic [2*DW-1:0] tbl_q;
  logic signed [DW-1:0] tc, ts, map_i, map_q, p2_i, p2_q;
  logic [DW-1:0]   g_sat;
  logic signed [2*DW:0] vi_ext, vq_ext, g_ext;
  logic [DW-1:0]   scaled_i, scaled_q;

  assign adv       = pcm_out_ready | ~pcm_out_valid;
  assign flush     = rst | resync;
  assign phase_top = (TAW+2)'((acc + phase_offset) >> (PW-TAW-2));
  assign status    = acc[PW-1:PW-TAW-2];

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge da_clk) begin
    if (flush) begin
      acc    <= '0;
      p0_qd  <= '0;
      p0_idx <= '0;
      p0_vld <= 1'b0;
    end else if (adv) begin
      acc    <= (mode == MODE_TONE) ? acc + phase_step : '0;
      p0_qd  <= phase_top[TAW+1:TAW];
      p0_idx <= phase_top[TAW-1:0];
      p0_vld <= 1'b1;
    end
  end

  generic_dpram #(.adw(2*DW), .bdw(2*DW), .aaw(TAW)) u_table (
    .clk_a  (da_clk),
    .addr_a (p0_idx),
    .rden_a (adv),
    .q_a    (tbl_q),
    .clk_b  (da_clk),
    .addr_b (reg_addr),
    .rden_b (reg_rd),
    .wren_b (reg_wr),
    .data_b (reg_writedata),
    .q_b    (reg_readdata)
  );

  always_ff @(posedge da_clk) begin
    if (flush) begin
      p1_qd  <= '0;
      p1_vld <= 1'b0;
    end else if (adv) begin
      p1_qd  <= p0_qd;
      p1_vld <= p0_vld;
    end
  end

  assign tc = tbl_q[2*DW-1:DW];
  assign ts = tbl_q[DW-1:0];

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    map_i = tc;
    map_q = ts;
    case (quad_e'(p1_qd))
      QD_0:   begin map_i = tc;  map_q = ts;  end
      QD_90:  begin map_i = -ts; map_q = tc;  end
      QD_180: begin map_i = -tc; map_q = -ts; end
      QD_270: begin map_i = ts;  map_q = -tc; end
      default: ;
    endcase
  end

  always_ff @(posedge da_clk) begin
    if (flush) begin
      p2_i   <= '0;
      p2_q   <= '0;
      p2_vld <= 1'b0;
    end else if (adv) begin
      p2_i   <= map_i;
      p2_q   <= map_q;
      p2_vld <= p1_vld;
    end
  end

  // Gain saturates at unity; slicing the full product is the arithmetic shift with floor rounding.
  assign g_sat    = (gain > GAIN_ONE) ? GAIN_ONE : gain;
  assign g_ext    = {{(DW+1){1'b0}}, g_sat};
  assign vi_ext   = {{(DW+1){p2_i[DW-1]}}, p2_i};
  assign vq_ext   = {{(DW+1){p2_q[DW-1]}}, p2_q};
  assign scaled_i = DW'((vi_ext * g_ext) >>> (DW-1));
  assign scaled_q = DW'((vq_ext * g_ext) >>> (DW-1));

  always_ff @(posedge da_clk) begin
    if (flush) begin
      pcm_out_valid <= 1'b0;
      ipcm_out      <= '0;
      qpcm_out      <= '0;
    end else if (adv) begin
      pcm_out_valid <= p2_vld;
      ipcm_out      <= '0;
      qpcm_out      <= '0;
      if (p2_vld) begin
        case (mode_e'(mode))
          MODE_TONE: begin ipcm_out <= scaled_i; qpcm_out <= scaled_q; end
          MODE_DC:   ipcm_out <= DW'(UNIT1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge da_clk) begin
    if (rst) reg_ready <= 1'b0;
    else     reg_ready <= (reg_rd | reg_wr) & ~reg_ready;
  end

endmodule

// File: tb/tb_sincos_dds.sv
// Self-checking bench for sincos_dds against a phase-arithmetic reference model.
module tb_sincos_dds;
  import sincos_dds_pkg::*;

  localparam int DW = 16, TAW = 10, PW = 32;

  logic          da_clk = 1'b0;
  logic          rst, resync;
  logic          pcm_out_valid, pcm_out_ready;
  logic [DW-1:0] ipcm_out, qpcm_out, gain;
  logic [TAW-1:0] reg_addr;
  logic          reg_rd, reg_wr, reg_ready;
  logic [31:0]   reg_writedata, reg_readdata;
  logic [1:0]    mode;
  logic [PW-1:0] phase_step, phase_offset;
  logic [TAW+1:0] status;

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic [31:0] tbl [1024];

  always #5 da_clk = ~da_clk;

  sincos_dds #(.DW(DW), .TAW(TAW), .PW(PW)) dut (
    .da_clk        (da_clk),
    .rst           (rst),
    .pcm_out_valid (pcm_out_valid),
    .pcm_out_ready (pcm_out_ready),
    .ipcm_out      (ipcm_out),
    .qpcm_out      (qpcm_out),
    .reg_addr      (reg_addr),
    .reg_rd        (reg_rd),
    .reg_wr        (reg_wr),
    .reg_ready     (reg_ready),
    .reg_writedata (reg_writedata),
    .reg_readdata  (reg_readdata),
    .mode          (mode),
    .phase_step    (phase_step),
    .phase_offset  (phase_offset),
    .gain          (gain),
    .resync        (resync),
    .status        (status)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge da_clk);
    #1;
  endtask

  // Expected I/Q for a given phase, written from the sine/cosine quadrant identities.
  function automatic void model(input logic [31:0] ph, input logic [1:0] md, input logic [15:0] gn,
                                output logic [15:0] ei, output logic [15:0] eq);
    int c, s, vi, vq, g;
    logic [31:0] e;
    if (md == 2'd1) begin
      ei = 16'h4000; eq = 16'h0000;
    end else if (md != 2'd2) begin
      ei = 16'h0000; eq = 16'h0000;
    end else begin
      e  = tbl[ph[29:20]];
      c  = int'($signed(e[31:16]));
      s  = int'($signed(e[15:0]));
      case (ph[31:30])
        2'd0:    begin vi = c;  vq = s;  end
        2'd1:    begin vi = -s; vq = c;  end
        2'd2:    begin vi = -c; vq = -s; end
        default: begin vi = s;  vq = -c; end
      endcase
      g  = (int'(gn) > 32768) ? 32768 : int'(gn);
      ei = 16'((longint'(vi) * longint'(g)) >>> 15);
      eq = 16'((longint'(vq) * longint'(g)) >>> 15);
    end
  endfunction

  task automatic reg_write(input int a, input logic [31:0] d);
    bit seen = 1'b0;
    reg_addr = 10'(a); reg_writedata = d; reg_wr = 1'b1;
    for (int t = 0; t < 4 && !seen; t++) begin
      step();
      if (reg_ready) seen = 1'b1;
    end
    reg_wr = 1'b0;
    step();
    tbl[a] = d;
    check("wr_ready", 64'(seen), 64'd1);
  endtask

  task automatic reg_read(input int a);
    bit seen = 1'b0;
    reg_addr = 10'(a); reg_rd = 1'b1;
    for (int t = 0; t < 4 && !seen; t++) begin
      step();
      if (reg_ready) seen = 1'b1;
    end
    check("rd_ready", 64'(seen), 64'd1);
    check("rd_data", 64'(reg_readdata), 64'(tbl[a]));
    reg_rd = 1'b0;
    step();
    check("rd_ready_low", 64'(reg_ready), 64'd0);
  endtask

  // rmode: 0 = always ready, 1 = random ready, 2 = five-cycle stall at sample 3.
  task automatic run_stream(input logic [31:0] off, input logic [31:0] stp, input logic [1:0] md,
                            input logic [15:0] gn, input int nsamp, input int rmode);
    int n = 0, cyc = 0, stalls = 0;
    logic rdy;
    logic [15:0] ei, eq;
    logic [31:0] ea;
    phase_offset = off; phase_step = stp; mode = md; gain = gn;
    pcm_out_ready = 1'b1; resync = 1'b1;
    step();
    resync = 1'b0;
    check("resync_valid_low", 64'(pcm_out_valid), 64'd0);
    for (int e = 1; e <= SDDS_LAT; e++) begin
      step();
      check("latency_valid", 64'(pcm_out_valid), 64'(e == SDDS_LAT));
    end
    while (n < nsamp && cyc < nsamp * 8 + 20) begin
      if (rmode == 1) rdy = 1'($urandom_range(0, 1));
      else if (rmode == 2 && n == 3 && stalls < 5) begin rdy = 1'b0; stalls++; end
      else rdy = 1'b1;
      pcm_out_ready = rdy;
      check("valid_held", 64'(pcm_out_valid), 64'd1);
      if (pcm_out_valid) begin
        model(off + stp * 32'(n), md, gn, ei, eq);
        ea = (md == 2'd2) ? stp * 32'(n + SDDS_LAT) : 32'd0;
        check("stream_i", 64'(ipcm_out), 64'(ei));
        check("stream_q", 64'(qpcm_out), 64'(eq));
        check("stream_status", 64'(status), 64'(ea[31:20]));
        if (rdy) n++;
      end
      step();
      cyc++;
    end
    check("stream_budget", 64'(n >= nsamp), 64'd1);
    pcm_out_ready = 1'b1;
  endtask

  initial begin
    logic [15:0] walk_i [4];
    logic [15:0] walk_q [4];
    walk_i = '{16'h7FFF, 16'h0000, 16'h8001, 16'h0000};
    walk_q = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8001};

    rst = 1'b1; resync = 1'b0; mode = 2'd1; pcm_out_ready = 1'b1; gain = 16'h8000;
    phase_step = '0; phase_offset = '0; reg_addr = '0; reg_rd = 1'b0; reg_wr = 1'b0;
    reg_writedata = '0;
    step(); step();
    check("rst_valid", 64'(pcm_out_valid), 64'd0);
    check("rst_i", 64'(ipcm_out), 64'd0);
    check("rst_q", 64'(qpcm_out), 64'd0);
    check("rst_reg_ready", 64'(reg_ready), 64'd0);
    check("rst_status", 64'(status), 64'd0);

    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("dc_valid_edge", 64'(pcm_out_valid), 64'(e == 4));
    end
    check("dc_i", 64'(ipcm_out), 64'h4000);
    check("dc_q", 64'(qpcm_out), 64'h0000);

    for (int i = 0; i < 1024; i++) begin
      int c, s;
      c = int'($urandom_range(0, 65534)) - 32767;
      s = int'($urandom_range(0, 65534)) - 32767;
      reg_write(i, {16'(c), 16'(s)});
    end
    reg_write(0, 32'h7FFF_0000);
    reg_write(512, 32'h5A82_5A82);
    for (int i = 0; i < 3; i++) reg_read(int'($urandom_range(0, 1023)));

    // Quadrant walk, then its fixed four-sample cycle.
    run_stream(32'h0, 32'h4000_0000, 2'd2, 16'h8000, 12, 0);
    for (int i = 0; i < 4; i++) begin
      check("walk_i", 64'(ipcm_out), 64'(walk_i[i]));
      check("walk_q", 64'(qpcm_out), 64'(walk_q[i]));
      step();
    end

    run_stream(32'h0, 32'h4000_0000, 2'd2, 16'h8000, 16, 2);

    run_stream(32'h2000_0000, 32'h0, 2'd2, 16'h4000, 4, 0);
    check("half_gain_i", 64'(ipcm_out), 64'h2D41);
    check("half_gain_q", 64'(qpcm_out), 64'h2D41);
    run_stream(32'h2000_0000, 32'h0, 2'd2, 16'hFFFF, 4, 0);
    check("sat_gain_i", 64'(ipcm_out), 64'h5A82);
    check("sat_gain_q", 64'(qpcm_out), 64'h5A82);

    run_stream(32'h9000_0000, $urandom, 2'd2, 16'h8000, 10, 0);

    for (int r = 0; r < 6; r++) begin
      logic [1:0] md;
      md = (r == 4) ? 2'd1 : (r == 5) ? 2'd3 : 2'd2;
      run_stream($urandom, $urandom, md, 16'($urandom_range(0, 65535)), 20, 1);
    end

    reg_write(3, 32'h1234_5678);
    reg_read(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
